// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: paces ADC conversions on one channel at a programmed
// sample period, buffers 12-bit results in a FIFO and streams each sample
// to the UART transmitter as two bytes (high nibble first, then low byte).
//
// Capture FSM
//   state  | meaning
//   IDLE   | waiting for start; shadow config may be rewritten freely
//   RUN    | issuing a conversion request every PERIOD cycles
//   DRAIN  | no new requests; finishing in-flight conversion, FIFO and TX
// TX FSM
//   state  | meaning
//   T_IDLE | waiting for a sample in the FIFO
//   T_HI   | high byte handed to UART, waiting for tx_done
//   T_LO   | low byte handed to UART, waiting for tx_done
module adc_capture_ctrl #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [7:0]  BASE_ADDR  = 8'h10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_wr,
    input  logic [7:0]  m_addr,
    input  logic [31:0] m_wrdata,
    output logic [2:0]  adc_channel,
    output logic        adc_en_conv,
    input  logic        adc_busy,
    input  logic        adc_conv_done,
    input  logic [11:0] adc_data,
    output logic        tx_byte_en,
    output logic [7:0]  tx_data_byte,
    input  logic        tx_done,
    output logic        cap_busy,
    output logic        overflow
);

    localparam int unsigned         DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [23:0]         MIN_PERIOD = 24'd16;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} cap_state_t;
    typedef enum logic [1:0] {T_IDLE, T_HI, T_LO} tx_state_t;

    cap_state_t cap_state, cap_next;
    tx_state_t  tx_state, tx_next;

    logic [2:0]  sh_chan;
    logic [23:0] sh_period;
    logic [15:0] sh_count;
    logic [23:0] period;
    logic [15:0] count;
    logic [23:0] per_cnt;
    logic [15:0] smp_cnt;
    logic        conv_pend;

    logic [11:0]           fifo_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   fifo_cnt;
    logic                  fifo_empty, fifo_full, push_req, push_ok, pop;
    logic [11:0]           tx_hold;

    logic wr_ctrl, start_cmd, stop_cmd, start_go;
    logic tick, conv_req, conv_skip, drain_done;
    logic en_conv_d, cap_busy_d, overflow_d, byte_en_d;
    logic [7:0] byte_d;
    logic unused_wrdata;

    assign unused_wrdata = &{1'b0, m_wrdata[31:24]};
    assign wr_ctrl    = m_wr && (m_addr == BASE_ADDR);
    assign start_cmd  = wr_ctrl && m_wrdata[0];
    assign stop_cmd   = wr_ctrl && m_wrdata[1];
    assign start_go   = (cap_state == IDLE) && start_cmd;
    // per_cnt is a down-counter; reaching zero means the request is
    // registered this cycle and appears on adc_en_conv at the wrap.
    assign tick       = (cap_state == RUN) && (per_cnt == '0);
    assign conv_req   = tick && !adc_busy;
    assign conv_skip  = tick && adc_busy;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign pop        = (tx_state == T_IDLE) && !fifo_empty;
    assign push_req   = adc_conv_done && (cap_state != IDLE);
    assign push_ok    = push_req && (!fifo_full || pop);
    assign drain_done = !conv_pend && !adc_en_conv && fifo_empty && (tx_state == T_IDLE);

    // Shadow configuration registers written by the command decoder.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sh_chan   <= '0;
            sh_period <= MIN_PERIOD;
            sh_count  <= '0;
        end else if (m_wr) begin
            if (m_addr == BASE_ADDR + 8'd1) sh_chan <= m_wrdata[2:0];
            if (m_addr == BASE_ADDR + 8'd2)
                sh_period <= (m_wrdata[23:0] < MIN_PERIOD) ? MIN_PERIOD : m_wrdata[23:0];
            if (m_addr == BASE_ADDR + 8'd3) sh_count <= m_wrdata[15:0];
        end
    end

    // Capture state register, working config, timers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cap_state   <= IDLE;
            adc_en_conv <= 1'b0;
            cap_busy    <= 1'b0;
            overflow    <= 1'b0;
            adc_channel <= '0;
            period      <= MIN_PERIOD;
            count       <= '0;
            per_cnt     <= '0;
            smp_cnt     <= '0;
            conv_pend   <= 1'b0;
        end else begin
            cap_state   <= cap_next;
            adc_en_conv <= en_conv_d;
            cap_busy    <= cap_busy_d;
            overflow    <= overflow_d;
            if (start_go) begin
                adc_channel <= sh_chan;
                period      <= sh_period;
                count       <= sh_count;
                per_cnt     <= sh_period - 24'd2;
                smp_cnt     <= '0;
            end else if (cap_state == RUN) begin
                per_cnt <= (per_cnt == '0) ? period - 24'd1 : per_cnt - 24'd1;
                if (conv_req) smp_cnt <= smp_cnt + 16'd1;
            end
            if (adc_en_conv)        conv_pend <= 1'b1;
            else if (adc_conv_done) conv_pend <= 1'b0;
        end
    end

    // Capture next-state logic.
    always_comb begin
        cap_next = cap_state;
        unique case (cap_state)
            IDLE:    if (start_cmd) cap_next = RUN;
            RUN:     if (stop_cmd || ((count != '0) && (smp_cnt == count))) cap_next = DRAIN;
            DRAIN:   if (drain_done) cap_next = IDLE;
            default: cap_next = IDLE;
        endcase
    end

    // Capture output logic, registered above.
    always_comb begin
        en_conv_d  = conv_req;
        cap_busy_d = (cap_next != IDLE);
        overflow_d = overflow;
        if (start_go)                                 overflow_d = 1'b0;
        else if (conv_skip || (push_req && !push_ok)) overflow_d = 1'b1;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (start_go) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (!push_ok && pop) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= adc_data;
    end

    // TX state register and registered UART outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state     <= T_IDLE;
            tx_byte_en   <= 1'b0;
            tx_data_byte <= '0;
            tx_hold      <= '0;
        end else begin
            tx_state     <= tx_next;
            tx_byte_en   <= byte_en_d;
            tx_data_byte <= byte_d;
            if (pop) tx_hold <= fifo_mem[rd_ptr];
        end
    end

    // TX next-state logic; tx_done in T_IDLE falls through unused.
    always_comb begin
        tx_next = tx_state;
        unique case (tx_state)
            T_IDLE:  if (!fifo_empty) tx_next = T_HI;
            T_HI:    if (tx_done) tx_next = T_LO;
            T_LO:    if (tx_done) tx_next = T_IDLE;
            default: tx_next = T_IDLE;
        endcase
    end

    // TX output logic: high nibble on pop, low byte after the first tx_done.
    always_comb begin
        byte_en_d = 1'b0;
        byte_d    = tx_data_byte;
        if (pop) begin
            byte_en_d = 1'b1;
            byte_d    = {4'h0, fifo_mem[rd_ptr][11:8]};
        end else if ((tx_state == T_HI) && tx_done) begin
            byte_en_d = 1'b1;
            byte_d    = tx_hold[7:0];
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: ADC and UART behavioural models, a byte
// scoreboard fed by the directed tests and drained by a monitor.
module tb_adc_capture_ctrl;

    localparam logic [7:0] BASE = 8'h10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m_wr = 1'b0;
    logic [7:0]  m_addr = '0;
    logic [31:0] m_wrdata = '0;
    logic [2:0]  adc_channel;
    logic        adc_en_conv;
    logic        adc_busy = 1'b0;
    logic        adc_conv_done = 1'b0;
    logic [11:0] adc_data = '0;
    logic        tx_byte_en;
    logic [7:0]  tx_data_byte;
    logic        tx_done = 1'b0;
    logic        cap_busy;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    adc_capture_ctrl #(.DEPTH_LOG2(4), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .m_wr(m_wr), .m_addr(m_addr), .m_wrdata(m_wrdata),
        .adc_channel(adc_channel), .adc_en_conv(adc_en_conv), .adc_busy(adc_busy),
        .adc_conv_done(adc_conv_done), .adc_data(adc_data),
        .tx_byte_en(tx_byte_en), .tx_data_byte(tx_data_byte), .tx_done(tx_done),
        .cap_busy(cap_busy), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC model: busy for adc_lat cycles after each request, then a done pulse.
    int          adc_lat = 10;
    logic        force_busy = 1'b0;
    logic        adc_fixed = 1'b1;
    logic [11:0] adc_base = '0;
    int          done_base = 0;
    int          done_cnt = 0;
    int          adc_cnt = 0;
    int          en_times[$];
    logic        prev_en = 1'b0;

    initial forever begin
        @(negedge clk);
        adc_conv_done = 1'b0;
        if (!rst) begin
            adc_cnt = 0;
        end else begin
            if (adc_cnt > 0) begin
                adc_cnt--;
                if (adc_cnt == 0) begin
                    adc_conv_done = 1'b1;
                    adc_data = adc_fixed ? adc_base : adc_base + 12'(done_cnt - done_base);
                    done_cnt++;
                end
            end
            if (adc_en_conv) begin
                chk("en_conv_width", 32'(prev_en), 0);
                en_times.push_back(cyc);
                adc_cnt = adc_lat;
            end
        end
        prev_en = adc_en_conv;
        adc_busy = (adc_cnt > 0) || force_busy;
    end

    // UART model: tx_done tx_lat+1 cycles after byte_en, held off while stalled.
    logic tx_stall = 1'b0;
    int   tx_cnt = 0;
    logic tx_pend = 1'b0;
    int   last_done = 0;

    initial forever begin
        @(negedge clk);
        tx_done = 1'b0;
        if (tx_pend && !tx_stall) begin
            if (tx_cnt > 0) tx_cnt--;
            else begin
                tx_done = 1'b1;
                tx_pend = 1'b0;
                last_done = cyc;
            end
        end
        if (tx_byte_en) begin
            tx_pend = 1'b1;
            tx_cnt = 5;
        end
    end

    // Scoreboard monitor.
    logic [7:0] sb[$];
    logic       prev_be = 1'b0;

    initial forever begin
        logic [7:0] exp_b;
        @(negedge clk);
        if (tx_byte_en) begin
            chk("byte_en_width", 32'(prev_be), 0);
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL tx_byte: got %02h, expected no byte (cycle %0d)", tx_data_byte, cyc);
            end else begin
                exp_b = sb.pop_front();
                chk("tx_byte", 32'(tx_data_byte), 32'(exp_b));
            end
        end
        prev_be = tx_byte_en;
    end

    int wr_cyc = 0;
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        m_wr = 1'b1;
        m_addr = a;
        m_wrdata = d;
        wr_cyc = cyc;
        @(negedge clk);
        m_wr = 1'b0;
    endtask

    int idle_cyc = 0;
    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget && cap_busy; i++) @(negedge clk);
        idle_cyc = cyc;
        chk(name, 32'(cap_busy), 0);
    endtask

    task automatic wait_en(input int target, input int budget);
        for (int i = 0; i < budget && en_times.size() < target; i++) @(negedge clk);
    endtask

    task automatic push_sample(input logic [11:0] d);
        sb.push_back({4'h0, d[11:8]});
        sb.push_back(d[7:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int e0, ts, stop_c;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_channel", 32'(adc_channel), 0);
        chk("rst_en_conv", 32'(adc_en_conv), 0);
        chk("rst_byte_en", 32'(tx_byte_en), 0);
        chk("rst_data_byte", 32'(tx_data_byte), 0);
        chk("rst_cap_busy", 32'(cap_busy), 0);
        chk("rst_overflow", 32'(overflow), 0);
        rst = 1'b1;

        // T1: CHAN 3, PERIOD 100, COUNT 4, slow ADC returning ABC.
        adc_lat = 40; adc_fixed = 1'b1; adc_base = 12'hABC;
        wr(BASE + 8'd1, 3); wr(BASE + 8'd2, 100); wr(BASE + 8'd3, 4);
        e0 = en_times.size();
        repeat (4) push_sample(12'hABC);
        wr(BASE, 1); ts = wr_cyc;
        chk("t1_busy_rise", 32'(cap_busy), 1);
        wait_idle("t1_idle", 1000);
        chk("t1_en_count", 32'(en_times.size() - e0), 4);
        chk("t1_first_en", 32'(en_times[e0] - ts), 100);
        chk("t1_spacing", 32'(en_times[e0+3] - en_times[e0]), 300);
        chk("t1_fall_after_done", 32'(idle_cyc - last_done), 2);
        chk("t1_channel", 32'(adc_channel), 3);
        chk("t1_overflow", 32'(overflow), 0);
        chk("t1_sb_empty", 32'(sb.size()), 0);

        // T2: PERIOD 5 clamps to 16.
        adc_lat = 10; adc_base = 12'h5A3;
        wr(BASE + 8'd2, 5); wr(BASE + 8'd3, 3);
        e0 = en_times.size();
        repeat (3) push_sample(12'h5A3);
        wr(BASE, 1); ts = wr_cyc;
        wait_idle("t2_idle", 500);
        chk("t2_en_count", 32'(en_times.size() - e0), 3);
        chk("t2_first_en", 32'(en_times[e0] - ts), 16);
        chk("t2_spacing", 32'(en_times[e0+2] - en_times[e0]), 32);
        chk("t2_sb_empty", 32'(sb.size()), 0);

        // T3: stop in IDLE does nothing; continuous run stopped after 10.
        wr(BASE, 2);
        chk("t3_stop_idle", 32'(cap_busy), 0);
        adc_fixed = 1'b0; adc_base = 12'h300; done_base = done_cnt;
        wr(BASE + 8'd2, 16); wr(BASE + 8'd3, 0);
        e0 = en_times.size();
        for (int i = 0; i < 10; i++) push_sample(12'h300 + 12'(i));
        wr(BASE, 1);
        wait_en(e0 + 10, 400);
        wr(BASE, 2); stop_c = wr_cyc;
        wait_idle("t3_idle", 500);
        chk("t3_en_count", 32'(en_times.size() - e0), 10);
        chk("t3_no_en_after_stop", 32'(en_times[en_times.size()-1] <= stop_c + 1), 1);
        chk("t3_sb_empty", 32'(sb.size()), 0);

        // T4: stalled UART, 20 conversions; 16 buffered + 1 in TX survive.
        adc_base = 12'h100; done_base = done_cnt; tx_stall = 1'b1;
        wr(BASE + 8'd3, 20);
        e0 = en_times.size();
        for (int i = 0; i < 17; i++) push_sample(12'h100 + 12'(i));
        wr(BASE, 1);
        wait_en(e0 + 20, 600);
        repeat (15) @(negedge clk);
        chk("t4_overflow", 32'(overflow), 1);
        chk("t4_still_busy", 32'(cap_busy), 1);
        tx_stall = 1'b0;
        wait_idle("t4_idle", 2000);
        chk("t4_en_count", 32'(en_times.size() - e0), 20);
        chk("t4_sb_empty", 32'(sb.size()), 0);

        // T5: busy held across the first wrap skips that tick.
        adc_fixed = 1'b1; adc_base = 12'h7E1; force_busy = 1'b1;
        wr(BASE + 8'd3, 2);
        e0 = en_times.size();
        repeat (2) push_sample(12'h7E1);
        wr(BASE, 1); ts = wr_cyc;
        chk("t5_ovf_cleared", 32'(overflow), 0);
        while (cyc < ts + 20) @(negedge clk);
        force_busy = 1'b0;
        wait_idle("t5_idle", 500);
        chk("t5_en_count", 32'(en_times.size() - e0), 2);
        chk("t5_first_en", 32'(en_times[e0] - ts), 32);
        chk("t5_overflow", 32'(overflow), 1);
        chk("t5_sb_empty", 32'(sb.size()), 0);

        // T6: reset mid-RUN with 5 samples queued, then a clean restart.
        adc_fixed = 1'b0; adc_base = 12'h200; done_base = done_cnt; tx_stall = 1'b1;
        wr(BASE + 8'd1, 5); wr(BASE + 8'd2, 40); wr(BASE + 8'd3, 0);
        sb.push_back(8'h02);
        wr(BASE, 1);
        for (int i = 0; i < 600 && (done_cnt - done_base) < 6; i++) @(negedge clk);
        chk("t6_six_done", 32'(done_cnt - done_base), 6);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("t6_rst_channel", 32'(adc_channel), 0);
        chk("t6_rst_en_conv", 32'(adc_en_conv), 0);
        chk("t6_rst_byte_en", 32'(tx_byte_en), 0);
        chk("t6_rst_data_byte", 32'(tx_data_byte), 0);
        chk("t6_rst_cap_busy", 32'(cap_busy), 0);
        chk("t6_rst_overflow", 32'(overflow), 0);
        tx_stall = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_sb_empty_pre", 32'(sb.size()), 0);
        adc_fixed = 1'b1; adc_base = 12'h456;
        wr(BASE + 8'd3, 2);
        e0 = en_times.size();
        repeat (2) push_sample(12'h456);
        wr(BASE, 1); ts = wr_cyc;
        wait_idle("t6_idle", 500);
        chk("t6_en_count", 32'(en_times.size() - e0), 2);
        chk("t6_first_en", 32'(en_times[e0] - ts), 16);
        chk("t6_spacing", 32'(en_times[e0+1] - en_times[e0]), 16);
        chk("t6_channel", 32'(adc_channel), 0);
        chk("t6_overflow", 32'(overflow), 0);
        chk("t6_sb_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Capture scheduler between the command decoder, the ADC128S022 driver and the UART byte transmitter. Paces ADC conversions on one channel at a programmable sample period and buffers the 12-bit results in a small FIFO. Streams each sample to the UART as two bytes, for a programmed sample count or continuously until stopped. Replaces ad-hoc sample/transmit sequencing in the scope top level.

## Interface
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 samples.
- BASE_ADDR, 8'h10: register window base on the m_* bus.

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- m_wr  in  1  register write strobe from cmd decoder, one cycle
- m_addr  in  8  register address
- m_wrdata  in  32  register write data
- adc_channel  out  3  channel to ADC driver
- adc_en_conv  out  1  conversion request pulse
- adc_busy  in  1  ADC driver busy (conversion in progress)
- adc_conv_done  in  1  one-cycle pulse, adc_data valid
- adc_data  in  12  conversion result
- tx_byte_en  out  1  one-cycle send request to UART tx
- tx_data_byte  out  8  byte to send, stable from byte_en until tx_done
- tx_done  in  1  one-cycle pulse, byte finished
- cap_busy  out  1  capture FSM not IDLE
- overflow  out  1  sticky: sample lost

## Operation
- Registers (write-only, decoded when m_wr and m_addr matches):
  - BASE+0 CTRL: bit0 = start, bit1 = stop. Both are self-clearing commands.
  - BASE+1 CHAN [2:0].
  - BASE+2 PERIOD [23:0]: sample period in clk cycles. Values 0..15 are clamped to 16.
  - BASE+3 COUNT [15:0]: samples per capture. 0 means continuous.
- CHAN, PERIOD and COUNT writes are shadow-only; they are latched into working copies at start.
- Capture FSM states: IDLE, RUN, DRAIN.
  - IDLE + start: latch config, clear period counter, sample counter, FIFO pointers and overflow; go to RUN. Start while not IDLE is ignored.
  - RUN: the period counter counts 0..P-1 and wraps.
    - At the wrap, if adc_busy=0, pulse adc_en_conv and increment the sample counter.
    - At the wrap, if adc_busy=1, skip the tick and set overflow; the skipped tick does not count.
    - When sample counter == COUNT (COUNT≠0), or on stop, go to DRAIN.
  - DRAIN: no new requests. Leave for IDLE when no conversion is outstanding, FIFO is empty and TX FSM is in T_IDLE.
  - Stop in IDLE: no effect.
- FIFO: each adc_conv_done pushes adc_data, in any state other than IDLE.
  - Push when full: the sample is dropped and overflow is set, unless a pop occurs in the same cycle, in which case the push is accepted.
  - Pointers wrap modulo 2^DEPTH_LOG2.
- TX FSM states: T_IDLE, T_HI, T_LO.
  - T_IDLE with FIFO non-empty: pop the head, drive tx_data_byte = {4'h0, d[11:8]}, pulse tx_byte_en, go to T_HI.
  - T_HI on tx_done: drive tx_data_byte = d[7:0], pulse tx_byte_en, go to T_LO.
  - T_LO on tx_done: go to T_IDLE.
  - tx_done while in T_IDLE is ignored.
- adc_channel holds the latched CHAN from start until the next start.

## Timing
- Reset values: adc_channel 0, adc_en_conv 0, tx_byte_en 0, tx_data_byte 0, cap_busy 0, overflow 0. Both FSMs go to idle and the FIFO is emptied; shadow registers reset to CHAN 0, PERIOD 16, COUNT 0.
- Reset mid-operation aborts immediately. A UART byte already in flight finishes in the tx module, and its tx_done is ignored.
- start write in cycle t: cap_busy=1 at t+1. The first adc_en_conv occurs at t+P, then every P cycles while adc_busy=0.
- All outputs are registered. adc_en_conv and tx_byte_en are exactly one cycle wide.
- adc_conv_done at cycle t with FIFO empty and TX idle: tx_byte_en at t+2. Second byte_en is one cycle after the first tx_done.
- Stop written at cycle t during RUN: no adc_en_conv after t+1.
- cap_busy falls one cycle after the DRAIN exit condition is met.

## Test plan
- CHAN=3, PERIOD=100, COUNT=4, start; ADC model returns 12'hABC after 40 cycles -> 4 en_conv pulses 100 cycles apart, adc_channel=3, byte stream 0A,BC ×4, cap_busy falls after the last tx_done, overflow=0.
- PERIOD=5 written -> en_conv pulses spaced 16 cycles (clamp).
- COUNT=0, start, run 10 samples, stop -> no further en_conv after stop+1; the in-flight conversion is still transmitted; return to IDLE.
- tx_done withheld (stalled UART), PERIOD=16, 20 conversions with DEPTH_LOG2=4 -> first 16 buffered plus 1 held in TX, remaining dropped, overflow=1, transmitted data in order with no corruption.
- adc_busy forced high at a wrap -> no en_conv, overflow=1, sample counter unchanged.
- Reset asserted mid-RUN with FIFO holding 5 samples -> next cycle all outputs at reset values; a following start works normally with an empty FIFO.
